pedal_assist_sequencer: RTL and testbench
=========================================

Name: pedal_assist_sequencer

Overview:
Controls when pedal-cadence pulses enable motor assist. It measures the interval between pedal sensor blips and qualifies cadence after a run of consecutive in-time blips. It ramps an assist level up to the rider's request and ramps it down on cadence loss, or drops it at once on brake. It sits between the pedal sensor input and the motor PWM/throttle path.

Parameters:
TIMEOUT_CYCLES, 25_000_000, max blip-to-blip interval (0.5 s @ 50 MHz) that still counts as pedalling
QUALIFY_BLIPS, 3, consecutive in-time rising edges required to enter assist
RAMP_STEP_CYCLES, 500_000, cycles between 1-LSB level steps (10 ms)
LEVEL_W, 8, width of assist level
DEBOUNCE_CYCLES, 250_000, minimum valid interval (5 ms); used only with BLIP_DEBOUNCE_EN

Ports:
clk50M  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
blips  input  1  raw pedal sensor pulse, asynchronous to clk50M
brake  input  1  brake lever, synchronous, active-high
assist_req  input  LEVEL_W  rider-requested target level; sampled every cycle
assist_en  output  1  motor assist enable
assist_level  output  LEVEL_W  current ramped assist level
seq_state  output  2  FSM state: 0 IDLE, 1 QUALIFY, 2 ASSIST, 3 RAMPDOWN
blip_period  output  27  last measured valid interval in clk50M cycles

Behaviour:
- Reset (asynchronous, any time, including mid-ramp): seq_state=IDLE, assist_en=0, assist_level=0, blip_period=0, all counters=0, synchronizer flops=0.
- blips passes through a 2-flop synchronizer. A rising edge ("edge") is flagged 3 cycles after the input transition: 2 sync flops plus 1 edge-detect flop.
- Interval counter: counts up each cycle and saturates at TIMEOUT_CYCLES. "timeout" = counter==TIMEOUT_CYCLES. On an edge, blip_period<=counter unless timed out, then the counter clears to 1.
- Qualify counter: counts edges up to QUALIFY_BLIPS. It clears on timeout or brake.
- FSM transitions, registered and evaluated each cycle in priority order:
  - brake=1 in any state -> IDLE; assist_level<=0 and assist_en<=0 in the same cycle. No ramp.
  - IDLE: edge -> QUALIFY, with qualify count=1.
  - QUALIFY: timeout -> IDLE. Qualify count reaching QUALIFY_BLIPS -> ASSIST, and assist_en<=1 on that transition.
  - ASSIST: every RAMP_STEP_CYCLES, assist_level moves 1 LSB toward assist_req. It holds when equal. It steps down if assist_req is lowered. Timeout -> RAMPDOWN.
  - RAMPDOWN: every RAMP_STEP_CYCLES, assist_level decrements by 1. An edge -> ASSIST, keeping the current level; no re-qualification. Level==0 -> IDLE, with assist_en<=0.
- Ramp timer: free-running modulo RAMP_STEP_CYCLES. It restarts at 0 on entry to ASSIST or RAMPDOWN, so the first step comes RAMP_STEP_CYCLES after entry.
- Saturation: assist_level never wraps. There is no decrement below 0 and no increment past assist_req. assist_req=0 in ASSIST ramps down to 0 but stays in ASSIST with assist_en=1.
- Simultaneous edge and timeout in the same cycle: timeout takes precedence. The edge restarts the interval counter but is not counted as valid.
- assist_en=1 exactly in ASSIST and RAMPDOWN.

Optional Feature:
BLIP_DEBOUNCE_EN
- Defined: an edge whose interval counter < DEBOUNCE_CYCLES is discarded. It is not counted, does not update blip_period and does not restart the counter.
- Undefined: every synchronized rising edge is accepted. DEBOUNCE_CYCLES is unused.

Test Plan:
(Bench uses TIMEOUT_CYCLES=1000, RAMP_STEP_CYCLES=10, QUALIFY_BLIPS=3, DEBOUNCE_CYCLES=50.)
1. Blips every 200 cycles, assist_req=8 -> ASSIST on 3rd edge with assist_en=1; assist_level=8 at 80 cycles after ASSIST entry, then holds; blip_period=200.
2. Two blips 200 apart, then none -> QUALIFY then IDLE 1000 cycles after the last edge counter restart; assist_en never 1.
3. In ASSIST at level 8, stop blips -> RAMPDOWN after 1000 cycles; level 0 after 80 more cycles; then IDLE with assist_en=0.
4. In ASSIST at level 8, assert brake 1 cycle -> next cycle seq_state=IDLE, assist_level=0, assist_en=0.
5. In RAMPDOWN at level 5, one blip -> ASSIST, ramping from 5 back to assist_req=8.
6. With BLIP_DEBOUNCE_EN, glitch pairs 20 cycles apart every 200 cycles -> blip_period=200 and qualification as in test 1. Without the macro -> blip_period=20 after the glitch edge. Also assert reset mid-ramp -> all outputs 0 immediately.

Source files
------------

// File: rtl/pedal_assist_sequencer_if.sv
// Pedal-assist sequencer signal bundle: sensor/brake/request inputs and assist outputs.
// master drives the inputs (sensor side), slave is the sequencer itself.
interface pedal_assist_sequencer_if #(
    parameter int unsigned LEVEL_W = 8
) ();
    logic               blips;
    logic               brake;
    logic [LEVEL_W-1:0] assist_req;
    logic               assist_en;
    logic [LEVEL_W-1:0] assist_level;
    logic [1:0]         seq_state;
    logic [26:0]        blip_period;

    modport master (
        output blips, brake, assist_req,
        input  assist_en, assist_level, seq_state, blip_period
    );

    modport slave (
        input  blips, brake, assist_req,
        output assist_en, assist_level, seq_state, blip_period
    );
endinterface

// File: rtl/pedal_assist_sequencer.sv
// Cadence-qualified motor assist sequencer with ramped assist level and instant brake cut.
// Optional macro BLIP_DEBOUNCE_EN rejects sensor edges arriving sooner than DEBOUNCE_CYCLES.
module pedal_assist_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES   = 25_000_000,
    parameter int unsigned QUALIFY_BLIPS    = 3,
    parameter int unsigned RAMP_STEP_CYCLES = 500_000,
    parameter int unsigned LEVEL_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES  = 250_000
) (
    input logic                     clk50M,
    input logic                     reset,
    pedal_assist_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUALIFY  = 2'd1,
        ASSIST   = 2'd2,
        RAMPDOWN = 2'd3
    } seqState_t;

    localparam int unsigned RAMP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam int unsigned QUAL_W = (QUALIFY_BLIPS > 0) ? $clog2(QUALIFY_BLIPS + 1) : 1;
    localparam logic [26:0]       TIMEOUT_V = 27'(TIMEOUT_CYCLES);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(QUALIFY_BLIPS - 1);

    if (DEBOUNCE_CYCLES >= TIMEOUT_CYCLES || TIMEOUT_CYCLES >= (1 << 27)) begin : gBadParams
        $error("pedal_assist_sequencer: interval parameters out of range");
    end

    logic              syncMeta, syncStable, syncDly, blipEdge;
    logic [26:0]       intervalCnt;
    logic [26:0]       blipPeriod;
    logic [QUAL_W-1:0] qualifyCnt;
    logic [RAMP_W-1:0] rampCnt;
    seqState_t         state;
    logic              assistEn;
    logic [LEVEL_W-1:0] assistLevel;

    logic timeout, debounceOk, acceptedEdge, validEdge, rampTick;

    always_comb begin
        timeout = (intervalCnt == TIMEOUT_V);
`ifdef BLIP_DEBOUNCE_EN
        debounceOk = (intervalCnt >= 27'(DEBOUNCE_CYCLES));
`else
        debounceOk = 1'b1;
`endif
        acceptedEdge = blipEdge & debounceOk;
        // a timed-out edge only restarts the interval; it never counts toward cadence
        validEdge    = acceptedEdge & ~timeout;
        rampTick     = (rampCnt == RAMP_LAST);
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            syncMeta   <= 1'b0;
            syncStable <= 1'b0;
            syncDly    <= 1'b0;
            blipEdge   <= 1'b0;
        end else begin
            syncMeta   <= bus.blips;
            syncStable <= syncMeta;
            syncDly    <= syncStable;
            blipEdge   <= syncStable & ~syncDly;
        end
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            intervalCnt <= '0;
            blipPeriod  <= '0;
        end else if (acceptedEdge) begin
            intervalCnt <= 27'd1;
            if (!timeout) blipPeriod <= intervalCnt;
        end else if (!timeout) begin
            intervalCnt <= intervalCnt + 27'd1;
        end
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            assistEn    <= 1'b0;
            assistLevel <= '0;
            qualifyCnt  <= '0;
            rampCnt     <= '0;
        end else begin
            rampCnt <= rampTick ? '0 : rampCnt + 1'b1;
            if (bus.brake) begin
                state       <= IDLE;
                assistEn    <= 1'b0;
                assistLevel <= '0;
                qualifyCnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        qualifyCnt <= '0;
                        if (validEdge) begin
                            if (QUALIFY_BLIPS <= 1) begin
                                state    <= ASSIST;
                                assistEn <= 1'b1;
                                rampCnt  <= '0;
                            end else begin
                                state      <= QUALIFY;
                                qualifyCnt <= QUAL_W'(1);
                            end
                        end
                    end
                    QUALIFY: begin
                        if (timeout) begin
                            state      <= IDLE;
                            qualifyCnt <= '0;
                        end else if (validEdge) begin
                            if (qualifyCnt == QUAL_LAST) begin
                                state      <= ASSIST;
                                assistEn   <= 1'b1;
                                rampCnt    <= '0;
                                qualifyCnt <= '0;
                            end else begin
                                qualifyCnt <= qualifyCnt + 1'b1;
                            end
                        end
                    end
                    ASSIST: begin
                        qualifyCnt <= '0;
                        if (timeout) begin
                            state   <= RAMPDOWN;
                            rampCnt <= '0;
                        end else if (rampTick) begin
                            if (assistLevel < bus.assist_req)      assistLevel <= assistLevel + 1'b1;
                            else if (assistLevel > bus.assist_req) assistLevel <= assistLevel - 1'b1;
                        end
                    end
                    RAMPDOWN: begin
                        qualifyCnt <= '0;
                        // the interval is saturated here, so any accepted edge resumes assist
                        if (acceptedEdge) begin
                            state   <= ASSIST;
                            rampCnt <= '0;
                        end else if (assistLevel == '0) begin
                            state    <= IDLE;
                            assistEn <= 1'b0;
                        end else if (rampTick) begin
                            assistLevel <= assistLevel - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.assist_en    = assistEn;
    assign bus.assist_level = assistLevel;
    assign bus.seq_state    = state;
    assign bus.blip_period  = blipPeriod;
endmodule

// File: tb/tb_pedal_assist_sequencer.sv
// Directed bench for pedal_assist_sequencer with a timestamp-based reference model.
// Build with or without BLIP_DEBOUNCE_EN; expectations follow the macro.
module tb_pedal_assist_sequencer;
    localparam int unsigned T  = 1000;
    localparam int unsigned R  = 10;
    localparam int unsigned Q  = 3;
    localparam int unsigned D  = 50;
    localparam int unsigned LW = 8;
`ifdef BLIP_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic clk50M = 1'b0;
    logic reset  = 1'b1;
    always #5 clk50M = ~clk50M;

    pedal_assist_sequencer_if #(.LEVEL_W(LW)) bus ();

    pedal_assist_sequencer #(
        .TIMEOUT_CYCLES(T), .QUALIFY_BLIPS(Q), .RAMP_STEP_CYCLES(R),
        .LEVEL_W(LW), .DEBOUNCE_CYCLES(D)
    ) u_dut (
        .clk50M(clk50M),
        .reset (reset),
        .bus   (bus)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model: time is tracked as cycle stamps, not counters.
    int   mCyc = 0, mRestart = 0, mEntry = 0, mQual = 0;
    int   mState = 0, mLevel = 0, mPeriod = 0;
    bit   mEn = 1'b0;
    logic [3:0] mHist = '0;
    int   mElapsed;
    bit   mTo, mEdge, mAcc, mValid, mStep;

    always @(posedge clk50M or posedge reset) begin
        if (reset) begin
            mCyc = 0; mRestart = 0; mEntry = 0; mQual = 0;
            mState = 0; mLevel = 0; mPeriod = 0; mEn = 1'b0; mHist = '0;
        end else begin
            mElapsed = mCyc - mRestart;
            if (mElapsed > int'(T)) mElapsed = T;
            mTo    = (mElapsed == int'(T));
            mEdge  = mHist[2] && !mHist[3];
            mAcc   = mEdge && (!DEB_EN || mElapsed >= int'(D));
            mValid = mAcc && !mTo;
            mStep  = (mCyc > mEntry) && ((mCyc - mEntry) % R == 0);
            if (mAcc) begin
                if (!mTo) mPeriod = mElapsed;
                mRestart = mCyc;
            end
            if (bus.brake) begin
                mState = 0; mLevel = 0; mQual = 0;
            end else begin
                case (mState)
                    0: if (mValid) begin mQual = 1; mState = 1; end
                    1: if (mTo) begin mState = 0; mQual = 0; end
                       else if (mValid) begin
                           mQual++;
                           if (mQual >= int'(Q)) begin mState = 2; mEntry = mCyc; end
                       end
                    2: if (mTo) begin mState = 3; mEntry = mCyc; end
                       else if (mStep) begin
                           if (mLevel < int'(bus.assist_req)) mLevel++;
                           else if (mLevel > int'(bus.assist_req)) mLevel--;
                       end
                    default: if (mAcc) begin mState = 2; mEntry = mCyc; end
                             else if (mLevel == 0) mState = 0;
                             else if (mStep) mLevel--;
                endcase
            end
            mEn   = (mState == 2) || (mState == 3);
            mHist = {mHist[2:0], bus.blips};
            mCyc++;
        end
    end

    task automatic compareModel();
        tests++;
        if (bus.seq_state !== 2'(mState) || bus.assist_en !== mEn ||
            bus.assist_level !== LW'(mLevel) || bus.blip_period !== 27'(mPeriod)) begin
            failed++;
            if (failed <= 20)
                $display("FAIL model t=%0t: state %0d want %0d, en %0d want %0d, level %0d want %0d, period %0d want %0d",
                         $time, bus.seq_state, mState, bus.assist_en, mEn,
                         bus.assist_level, mLevel, bus.blip_period, mPeriod);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk50M);
            compareModel();
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic blip(input int gap);
        bus.blips = 1'b1;
        ticks(5);
        bus.blips = 1'b0;
        ticks(gap - 5);
    endtask

    task automatic glitchPair(input string tag, input int expMain, input int expGlitch);
        bus.blips = 1'b1;
        ticks(4);
        check({tag, "_main_period"}, 32'(bus.blip_period), 32'(expMain));
        ticks(1);
        bus.blips = 1'b0;
        ticks(15);
        bus.blips = 1'b1;
        ticks(4);
        check({tag, "_glitch_period"}, 32'(bus.blip_period), 32'(expGlitch));
        ticks(1);
        bus.blips = 1'b0;
        ticks(175);
    endtask

    initial begin
        bus.blips = 1'b0;
        bus.brake = 1'b0;
        bus.assist_req = '0;
        ticks(3);
        check("reset_state",  32'(bus.seq_state),    0);
        check("reset_en",     32'(bus.assist_en),    0);
        check("reset_level",  32'(bus.assist_level), 0);
        check("reset_period", 32'(bus.blip_period),  0);
        reset = 1'b0;
        bus.assist_req = 8'd8;
        ticks(150);

        // qualify on the third in-time edge, then ramp to 8
        blip(200);
        blip(200);
        bus.blips = 1'b1;
        ticks(3);
        check("t1_pre_assist", 32'(bus.seq_state), 1);
        ticks(1);
        check("t1_assist",     32'(bus.seq_state), 2);
        check("t1_en",         32'(bus.assist_en), 1);
        check("t1_period",     32'(bus.blip_period), 200);
        ticks(1);
        bus.blips = 1'b0;
        ticks(78);
        check("t1_level79", 32'(bus.assist_level), 7);
        ticks(1);
        check("t1_level80", 32'(bus.assist_level), 8);
        ticks(50);
        check("t1_hold", 32'(bus.assist_level), 8);

        // cadence loss, partial ramp-down, resume from level 5
        ticks(869);
        check("t3_before_to", 32'(bus.seq_state), 2);
        ticks(1);
        check("t3_rampdown",  32'(bus.seq_state), 3);
        ticks(30);
        check("t5_level5",    32'(bus.assist_level), 5);
        bus.blips = 1'b1;
        ticks(4);
        check("t5_resume",    32'(bus.seq_state), 2);
        check("t5_keep_lvl",  32'(bus.assist_level), 5);
        bus.blips = 1'b0;
        ticks(29);
        check("t5_level7", 32'(bus.assist_level), 7);
        ticks(1);
        check("t5_level8", 32'(bus.assist_level), 8);

        // full ramp-down to IDLE
        ticks(970);
        check("t3_rampdown2", 32'(bus.seq_state), 3);
        ticks(80);
        check("t3_level0",    32'(bus.assist_level), 0);
        check("t3_en_hold",   32'(bus.assist_en), 1);
        ticks(1);
        check("t3_idle",      32'(bus.seq_state), 0);
        check("t3_en_off",    32'(bus.assist_en), 0);

        // after a long idle the first edge is timed out and only restarts timing
        bus.blips = 1'b1;
        ticks(4);
        check("t4_stale_edge", 32'(bus.seq_state), 0);
        bus.blips = 1'b0;
        ticks(196);
        blip(200);
        blip(200);
        bus.blips = 1'b1;
        ticks(4);
        check("t4_assist", 32'(bus.seq_state), 2);
        bus.blips = 1'b0;
        ticks(40);
        check("t4_level4", 32'(bus.assist_level), 4);
        bus.brake = 1'b1;
        ticks(1);
        bus.brake = 1'b0;
        check("t4_brake_state", 32'(bus.seq_state), 0);
        check("t4_brake_level", 32'(bus.assist_level), 0);
        check("t4_brake_en",    32'(bus.assist_en), 0);
        check("t4_period",      32'(bus.blip_period), 200);

        // two blips then silence: QUALIFY times out to IDLE
        ticks(100);
        bus.blips = 1'b1;
        ticks(4);
        check("t2_qualify1", 32'(bus.seq_state), 1);
        bus.blips = 1'b0;
        ticks(196);
        bus.blips = 1'b1;
        ticks(4);
        check("t2_qualify2", 32'(bus.seq_state), 1);
        bus.blips = 1'b0;
        ticks(999);
        check("t2_before_to", 32'(bus.seq_state), 1);
        ticks(1);
        check("t2_idle",      32'(bus.seq_state), 0);
        check("t2_en",        32'(bus.assist_en), 0);

        // glitch pairs 20 cycles apart every 200 cycles
        glitchPair("t6_p1", 200, DEB_EN ? 200 : 20);
        glitchPair("t6_p2", DEB_EN ? 200 : 180, DEB_EN ? 200 : 20);
        glitchPair("t6_p3", DEB_EN ? 200 : 180, DEB_EN ? 200 : 20);
        glitchPair("t6_p4", DEB_EN ? 200 : 180, DEB_EN ? 200 : 20);
        check("t6_assist", 32'(bus.seq_state), 2);

        // request dropped to zero: level falls but assist stays engaged
        bus.assist_req = 8'd0;
        ticks(30);
        check("req0_state", 32'(bus.seq_state), 2);
        check("req0_en",    32'(bus.assist_en), 1);
        bus.assist_req = 8'd20;
        ticks(20);

        // asynchronous reset mid-ramp
        #2;
        reset = 1'b1;
        #1;
        check("rst_state",  32'(bus.seq_state),    0);
        check("rst_en",     32'(bus.assist_en),    0);
        check("rst_level",  32'(bus.assist_level), 0);
        check("rst_period", 32'(bus.blip_period),  0);
        ticks(2);
        reset = 1'b0;
        ticks(20);
        check("post_rst_idle", 32'(bus.seq_state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
